// File: rtl/ysyx_25030093_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_25030093_ifu: PC-in / instruction-out fetch stage over AXI4-Lite AR+R.
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_25030093_ifu #(
  parameter logic [31:0] NOP_INST    = 32'h00000013,
  parameter int          ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic [31:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        err_q, err_d;
  logic        flush_pend_q, flush_pend_d;
  logic        misaligned;

  assign misaligned = (ALIGN_CHECK != 0) && (pc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= 32'h0;
      inst_q       <= 32'h0;
      err_q        <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      err_q        <= err_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    err_d        = err_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      S_IDLE: begin
        if (pc_valid && !flush) begin
          pc_d         = pc;
          flush_pend_d = 1'b0;
          if (misaligned) begin
            inst_d  = NOP_INST;
            err_d   = 1'b1;
            state_d = S_OUT;
          end else begin
            err_d   = 1'b0;
            state_d = S_AR;
          end
        end
      end
      S_AR: begin
        // The address beat must still complete after a redirect; remember to drop its data.
        if (flush) flush_pend_d = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          if (flush_pend_q || flush) begin
            flush_pend_d = 1'b0;
            state_d      = S_IDLE;
          end else begin
            inst_d  = rdata;
            err_d   = (rresp != 2'b00);
            state_d = S_OUT;
          end
        end else if (flush) begin
          flush_pend_d = 1'b1;
        end
      end
      S_OUT: begin
        if (flush || inst_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign araddr     = pc_q;
  assign arvalid    = (state_q == S_AR);
  assign rready     = (state_q == S_R);
  assign inst_valid = (state_q == S_OUT);
  assign inst       = inst_q;
  assign inst_pc    = pc_q;
  assign fetch_err  = err_q && (state_q == S_OUT);
  assign pc_ready   = rst && (state_q == S_IDLE) && !(pc_valid && flush);

endmodule

`default_nettype wire
